// File: rtl/sequential_multiplier_if.sv
// -----------------------------------------------------------------------------
// sequential_multiplier_if
// Request/result bundle between a multiply requester and sequential_multiplier.
//   start   : request a multiply (requester -> multiplier)
//   a, b    : multiplicand / multiplier, captured when start is accepted
//   busy    : multiplier is iterating
//   done    : one-cycle pulse, product is final
//   product : live {hi, lo} product register, 2*width bits
// Modports: master = requester side, slave = multiplier side.
// -----------------------------------------------------------------------------
interface sequential_multiplier_if #(
   parameter int width = 8
);
   logic                 start;
   logic [width-1:0]     a;
   logic [width-1:0]     b;
   logic                 busy;
   logic                 done;
   logic [2*width-1:0]   product;

   modport master (
      output start, a, b,
      input  busy, done, product
   );

   modport slave (
      input  start, a, b,
      output busy, done, product
   );
endinterface

// File: rtl/sequential_multiplier.sv
// -----------------------------------------------------------------------------
// sequential_multiplier
// Shift-and-add multiplier built around a single adder_subtractor. One partial
// product is accumulated per clock; a multiply takes width iterations and the
// result is flagged by a one-cycle done pulse (width+1 cycles after start).
//
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-high reset (aborts any multiply in flight)
//   mul   : sequential_multiplier_if.slave (start, a, b, busy, done, product)
//
// Build option:
//   MULTIPLIER_SIGNED_EN : when defined, a, b and product are two's complement;
//                          otherwise they are unsigned. Ports and latency are
//                          identical in both builds.
//
// Also contains adder_subtractor: a b-bit adder whose second operand is
// XOR-ed with subtract and whose carry-in is subtract (a - b when subtract=1).
// -----------------------------------------------------------------------------

module adder_subtractor #(
   parameter int b = 8
) (
   input  logic [b-1:0] a_i,
   input  logic [b-1:0] b_i,
   input  logic         subtract_i,
   output logic [b-1:0] r_o,
   output logic         carry_o
);
   logic [b-1:0] b_eff;
   logic [b:0]   sum;

   always_comb begin
      b_eff = b_i ^ {b{subtract_i}};
      sum   = {1'b0, a_i} + {1'b0, b_eff} + {{b{1'b0}}, subtract_i};
   end

   assign r_o     = sum[b-1:0];
   assign carry_o = sum[b];
endmodule

module sequential_multiplier #(
   parameter int width = 8
) (
   input  logic                        clock,
   input  logic                        reset,
   sequential_multiplier_if.slave      mul
);
   localparam int CNT_W = $clog2(width) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [width-1:0] m_q,  m_d;
   logic [width-1:0] hi_q, hi_d;
   logic [width-1:0] lo_q, lo_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic             last_iter;
   logic             accept;
   logic [width-1:0] addend;
   logic             sub_step;
   logic [width-1:0] add_r;
   logic             add_carry;
   logic             top;

   assign last_iter = (count_q == CNT_W'(width - 1));
   // start is honoured only outside RUN; a re-pulse mid-multiply is dropped.
   assign accept    = mul.start && (state_q != RUN);

   // ---- adder stage: add m (or zero) into the accumulator ------------------
   assign addend = lo_q[0] ? m_q : '0;

`ifdef MULTIPLIER_SIGNED_EN
   // The multiplier's sign bit carries weight -2^(width-1), so the final
   // partial product is subtracted instead of added.
   assign sub_step = lo_q[0] && last_iter;

   logic [width-1:0] b_eff;
   assign b_eff = addend ^ {width{sub_step}};
   // True sign of the (width+1)-bit sum: sign-extend both operands and add.
   assign top   = hi_q[width-1] ^ b_eff[width-1] ^ add_carry;
`else
   assign sub_step = 1'b0;
   assign top      = add_carry;
`endif

   adder_subtractor #(
      .b (width)
   ) u_adder (
      .a_i        (hi_q),
      .b_i        (addend),
      .subtract_i (sub_step),
      .r_o        (add_r),
      .carry_o    (add_carry)
   );

   // ---- FSM: state register ------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---- FSM: next-state logic ----------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    state_d = mul.start ? RUN : IDLE;
         RUN:     state_d = last_iter ? DONE : RUN;
         DONE:    state_d = mul.start ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---- FSM: outputs -------------------------------------------------------
   always_comb begin
      mul.busy = (state_q == RUN);
      mul.done = (state_q == DONE);
   end

   assign mul.product = {hi_q, lo_q};

   // ---- datapath next-state ------------------------------------------------
   always_comb begin
      m_d     = m_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      count_d = count_q;
      if (accept) begin
         m_d     = mul.a;
         hi_d    = '0;
         lo_d    = mul.b;
         count_d = '0;
      end else if (state_q == RUN) begin
         // Shift the sum right by one; the consumed multiplier bit drops out
         // of lo while the low product bit shifts in from the top.
         {hi_d, lo_d} = {top, add_r, lo_q[width-1:1]};
         count_d      = count_q + CNT_W'(1);
      end
   end

   // ---- datapath registers -------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         m_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         count_q <= '0;
      end else begin
         m_q     <= m_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         count_q <= count_d;
      end
   end
endmodule

// File: tb/tb_sequential_multiplier.sv
// -----------------------------------------------------------------------------
// tb_sequential_multiplier
// Directed and randomized checks of sequential_multiplier against an
// arithmetic reference product. Follows MULTIPLIER_SIGNED_EN like the design.
// -----------------------------------------------------------------------------
module tb_sequential_multiplier;
   localparam int W = 8;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   sequential_multiplier_if #(.width(W)) bus ();

   sequential_multiplier #(.width(W)) dut (
      .clock (clk),
      .reset (rst),
      .mul   (bus)
   );

   initial clk = 1'b0;
   always #100 clk = ~clk;

   function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
      int p;
`ifdef MULTIPLIER_SIGNED_EN
      p = int'($signed(x)) * int'($signed(y));
`else
      p = int'({24'd0, x}) * int'({24'd0, y});
`endif
      return p[2*W-1:0];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issues a one-cycle start at the current negedge and follows the multiply
   // to its done cycle. Returns at the negedge inside the done cycle.
   task automatic do_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                         input string tag, input bit pulse_mid);
      logic [2*W-1:0] exp;
      int cyc;
      bit seen;
      exp = ref_mul(x, y);
      bus.start = 1'b1;
      bus.a     = x;
      bus.b     = y;
      @(posedge clk);
      #1 bus.start = 1'b0;
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 20) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) chk({tag, "_busy1"}, 32'(bus.busy), 32'd1);
         if (pulse_mid && cyc == 3) begin
            bus.start = 1'b1;
            bus.a     = ~x;
            bus.b     = y + 8'd1;
         end else begin
            bus.start = 1'b0;
         end
         if (bus.done) seen = 1'b1;
      end
      chk({tag, "_latency"}, 32'(cyc), 32'd9);
      chk({tag, "_product"}, 32'(bus.product), 32'(exp));
   endtask

   initial begin
      int cyc;
      bit seen;
      logic [W-1:0] ra, rb;
      checks    = 0;
      failures  = 0;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_product", 32'(bus.product), 32'd0);

      // Reset wins over start
      bus.start = 1'b1;
      bus.a = 8'd7;
      bus.b = 8'd9;
      @(negedge clk);
      chk("rst_vs_start_busy", 32'(bus.busy), 32'd0);
      bus.start = 1'b0;
      rst = 1'b0;
      @(negedge clk);

      // Directed vectors (identical expectations in both builds where noted)
      do_mul(8'd13, 8'd11, "m13x11", 1'b0);
      chk("m13x11_const", 32'(bus.product), 32'h008F);
      @(negedge clk);
      chk("idle_after_done", 32'({bus.busy, bus.done}), 32'd0);
      chk("hold_after_done", 32'(bus.product), 32'(ref_mul(8'd13, 8'd11)));

      do_mul(8'hFF, 8'hFF, "mFFxFF", 1'b0);
      @(negedge clk);
      do_mul(8'hFD, 8'h05, "mFDx05", 1'b0);
`ifdef MULTIPLIER_SIGNED_EN
      chk("mFDx05_const", 32'(bus.product), 32'hFFF1);
`else
      chk("mFDx05_const", 32'(bus.product), 32'h04F1);
`endif
      @(negedge clk);
      do_mul(8'h80, 8'h80, "m80x80", 1'b0);
      @(negedge clk);
      do_mul(8'h05, 8'hFD, "m05xFD", 1'b0);
      @(negedge clk);
      do_mul(8'h00, 8'hA5, "m00xA5", 1'b0);
      @(negedge clk);
      do_mul(8'h7F, 8'h81, "m7Fx81", 1'b0);

      // start re-pulsed mid-RUN is ignored
      @(negedge clk);
      do_mul(8'd37, 8'd91, "midstart", 1'b1);

      // Back-to-back: start held in the done cycle
      @(negedge clk);
      do_mul(8'd21, 8'd6, "b2b_first", 1'b0);
      chk("b2b_done_prior", 32'(bus.product), 32'(ref_mul(8'd21, 8'd6)));
      do_mul(8'd2, 8'd3, "b2b_second", 1'b0);
      chk("b2b_const", 32'(bus.product), 32'h0006);

      // Reset during RUN at the 3rd busy cycle
      @(negedge clk);
      bus.start = 1'b1;
      bus.a = 8'd99;
      bus.b = 8'd77;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort_busy_before", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_done", 32'(bus.done), 32'd0);
      chk("abort_product", 32'(bus.product), 32'h0000);
      rst  = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (bus.done || bus.busy) seen = 1'b1;
      end
      chk("abort_no_done", 32'(seen), 32'd0);

      // Randomized operands, alternating idle gaps and back-to-back issue
      for (int i = 0; i < 24; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         if (i % 3 == 0) ra = (i % 2 == 0) ? 8'h80 : 8'hFF;
         do_mul(ra, rb, $sformatf("rnd%0d", i), i % 4 == 1);
         if (i % 2 == 0) @(negedge clk);
      end

      cyc = checks;
      $display("TB_RESULT checks=%0d failures=%0d", cyc, failures);
      $finish;
   end
endmodule
